// File: rtl/sa_main_if.sv
// ---------------------------------------------------------------------------
// sa_main_if
//   Bundles the request/grant signals between the five router input ports,
//   the five output ports and the main switch allocator (sa_main).
//
//   Signals (per input port Px, x = 0..4):
//     req_from_Px   [`N]  one-hot requested output port, all-zero = no request
//     head_from_Px  [1]   requesting flit is a head flit
//     tail_from_Px  [1]   requesting flit is a tail flit (head+tail = 1-flit pkt)
//     grant_to_Px   [1]   flit wins this cycle, input buffer pops at clk edge
//   Signals (per output port OPx):
//     ready_of_OPx  [1]   downstream credit available
//     sel_for_OPx   [`N]  one-hot winning input (crossbar select), 0 = idle
//
//   Modports:
//     master : router side, drives requests/flags/credits, observes results
//     slave  : the allocator, consumes requests, drives selects and grants
//
//   `N (port count) defaults to 5 when not defined globally.
// ---------------------------------------------------------------------------
`ifndef N
`define N 5
`endif

interface sa_main_if;
  logic [`N-1:0] req_from_P0;
  logic [`N-1:0] req_from_P1;
  logic [`N-1:0] req_from_P2;
  logic [`N-1:0] req_from_P3;
  logic [`N-1:0] req_from_P4;

  logic head_from_P0, head_from_P1, head_from_P2, head_from_P3, head_from_P4;
  logic tail_from_P0, tail_from_P1, tail_from_P2, tail_from_P3, tail_from_P4;
  logic ready_of_OP0, ready_of_OP1, ready_of_OP2, ready_of_OP3, ready_of_OP4;

  logic [`N-1:0] sel_for_OP0;
  logic [`N-1:0] sel_for_OP1;
  logic [`N-1:0] sel_for_OP2;
  logic [`N-1:0] sel_for_OP3;
  logic [`N-1:0] sel_for_OP4;

  logic grant_to_P0, grant_to_P1, grant_to_P2, grant_to_P3, grant_to_P4;

  modport master (
    output req_from_P0, req_from_P1, req_from_P2, req_from_P3, req_from_P4,
    output head_from_P0, head_from_P1, head_from_P2, head_from_P3, head_from_P4,
    output tail_from_P0, tail_from_P1, tail_from_P2, tail_from_P3, tail_from_P4,
    output ready_of_OP0, ready_of_OP1, ready_of_OP2, ready_of_OP3, ready_of_OP4,
    input  sel_for_OP0, sel_for_OP1, sel_for_OP2, sel_for_OP3, sel_for_OP4,
    input  grant_to_P0, grant_to_P1, grant_to_P2, grant_to_P3, grant_to_P4
  );

  modport slave (
    input  req_from_P0, req_from_P1, req_from_P2, req_from_P3, req_from_P4,
    input  head_from_P0, head_from_P1, head_from_P2, head_from_P3, head_from_P4,
    input  tail_from_P0, tail_from_P1, tail_from_P2, tail_from_P3, tail_from_P4,
    input  ready_of_OP0, ready_of_OP1, ready_of_OP2, ready_of_OP3, ready_of_OP4,
    output sel_for_OP0, sel_for_OP1, sel_for_OP2, sel_for_OP3, sel_for_OP4,
    output grant_to_P0, grant_to_P1, grant_to_P2, grant_to_P3, grant_to_P4
  );
endinterface

// File: rtl/sa_main.sv
// ---------------------------------------------------------------------------
// sa_main
//   Main switch allocator of the 5-port router. For every output port a
//   round-robin arbiter picks one of the inputs requesting that output and
//   drives the one-hot crossbar select; the per-input grant (OR of all the
//   selects) is the dequeue strobe of the input buffer. Grants are
//   combinational from the current requests and state; state updates at clk.
//
//   Ports:
//     clk  : router clock
//     rst  : synchronous active-high reset (forces selects/grants to 0)
//     bus  : sa_main_if.slave (requests, head/tail flags, credits in;
//            crossbar selects and grants out)
//
//   Configuration:
//     SA_PKT_LOCK_EN defined   : per-output wormhole lock FSM; an output is
//                                held by one input from head to tail flit.
//     SA_PKT_LOCK_EN undefined : every flit arbitrated independently, pointer
//                                advances past the winner after every grant,
//                                head/tail flags are ignored.
// ---------------------------------------------------------------------------
`ifndef N
`define N 5
`endif

module sa_main (
  input  logic     clk,
  input  logic     rst,
  sa_main_if.slave bus
);

  localparam int NP = `N;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;

  logic [NP-1:0] req   [NP];
  logic [NP-1:0] elig  [NP];
  logic [NP-1:0] sel   [NP];
  logic [PW-1:0] win   [NP];
  logic [PW-1:0] ptr   [NP];
  logic [NP-1:0] win_valid;
  logic [NP-1:0] ready;
  logic [NP-1:0] grant;

`ifdef SA_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state [NP];
  logic [PW-1:0] owner [NP];
  logic [NP-1:0] head;
  logic [NP-1:0] tail;

  assign head = {bus.head_from_P4, bus.head_from_P3, bus.head_from_P2,
                 bus.head_from_P1, bus.head_from_P0};
  assign tail = {bus.tail_from_P4, bus.tail_from_P3, bus.tail_from_P2,
                 bus.tail_from_P1, bus.tail_from_P0};
`endif

  assign req[0] = bus.req_from_P0;
  assign req[1] = bus.req_from_P1;
  assign req[2] = bus.req_from_P2;
  assign req[3] = bus.req_from_P3;
  assign req[4] = bus.req_from_P4;

  assign ready = {bus.ready_of_OP4, bus.ready_of_OP3, bus.ready_of_OP2,
                  bus.ready_of_OP1, bus.ready_of_OP0};

  assign bus.sel_for_OP0 = sel[0];
  assign bus.sel_for_OP1 = sel[1];
  assign bus.sel_for_OP2 = sel[2];
  assign bus.sel_for_OP3 = sel[3];
  assign bus.sel_for_OP4 = sel[4];

  assign bus.grant_to_P0 = grant[0];
  assign bus.grant_to_P1 = grant[1];
  assign bus.grant_to_P2 = grant[2];
  assign bus.grant_to_P3 = grant[3];
  assign bus.grant_to_P4 = grant[4];

  // First set bit of r at or after position p, searching cyclically.
  // Returns {found, index}. The loop runs downward so that the smallest
  // offset from p is the last (and therefore winning) assignment.
  function automatic logic [PW:0] rr_pick(input logic [NP-1:0] r,
                                          input logic [PW-1:0] p);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int k = NP - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= NP) idx = idx - NP;
      if (r[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  // Cyclic successor of a port index (4 wraps to 0).
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    if (int'(i) >= NP - 1) return '0;
    else                   return i + PW'(1);
  endfunction

  // Transpose the per-input requests into per-output eligibility vectors:
  // elig[o][i] is set when input i asks for output o.
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        elig[o][i] = req[i][o];
      end
    end
  end

  // Per-output winner selection. Nothing is granted during reset or while
  // the output has no credit. A locked output only listens to its owner,
  // even if other inputs are requesting it.
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      win[o]       = '0;
      win_valid[o] = 1'b0;
      if (!rst && ready[o]) begin
`ifdef SA_PKT_LOCK_EN
        if (state[o] == LOCKED) begin
          win[o]       = owner[o];
          win_valid[o] = elig[o][owner[o]];
        end else begin
          {win_valid[o], win[o]} = rr_pick(elig[o], ptr[o]);
        end
`else
        {win_valid[o], win[o]} = rr_pick(elig[o], ptr[o]);
`endif
      end
      sel[o] = win_valid[o] ? (NP'(1) << win[o]) : '0;
    end
  end

  // Each input asks for a single output, so at most one select carries a
  // given input's bit and the OR is the input's grant.
  always_comb begin
    grant = '0;
    for (int o = 0; o < NP; o++) begin
      grant = grant | sel[o];
    end
  end

  // Per-output state. The pointer only moves when a packet finishes (or,
  // without packet locking, after every granted flit), so an input that just
  // released the output becomes the lowest priority one. A tail grant frees
  // the output at this edge; a new head competes from the next cycle on.
  always_ff @(posedge clk) begin
    for (int o = 0; o < NP; o++) begin
      if (rst) begin
        ptr[o]   <= '0;
`ifdef SA_PKT_LOCK_EN
        state[o] <= IDLE;
        owner[o] <= '0;
`endif
      end else if (win_valid[o]) begin
`ifdef SA_PKT_LOCK_EN
        if (tail[win[o]]) begin
          state[o] <= IDLE;
          ptr[o]   <= next_idx(win[o]);
        end else if (state[o] == IDLE) begin
          state[o] <= LOCKED;
          owner[o] <= win[o];
        end
`else
        ptr[o] <= next_idx(win[o]);
`endif
      end
    end
  end

  // Protocol checks: a request must name at most one output.
  for (genvar i = 0; i < NP; i++) begin : g_req_chk
    a_req_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0(req[i]));
  end

`ifdef SA_PKT_LOCK_EN
  // The owner of a locked output must not present another head flit.
  for (genvar o = 0; o < NP; o++) begin : g_lock_chk
    a_no_head_locked: assert property (@(posedge clk) disable iff (rst)
      (state[o] == LOCKED && elig[o][owner[o]]) |-> !head[owner[o]]);
  end
`endif

endmodule
